avalon_pio_gen2: RTL

Parametrised second-generation Avalon-MM parallel I/O block, the successor to the fixed 32-bit output-only PIO in soc_system. It adds the following:
- configurable width
- per-bit direction (tristate enable)
- synchronised input path with edge capture
- maskable level interrupt to the HPS
It sits on the lightweight HPS-to-FPGA bridge. Software uses it for sensor control lines and tilt-alert inputs.

---
 rtl/pio_gen2_pkg.sv | 15 +
 rtl/pio_sync_edge.sv | 47 ++++
 rtl/avalon_pio_gen2.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pio_gen2_pkg.sv
// Shared register addresses and edge-mode encodings for the second-generation PIO.
package pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin synchroniser plus previous-sample flop and edge select; in_sync lags pins by SYNC_STAGES cycles,
// edge_pulse is combinational from in_sync/in_prev. No backpressure: free-running every cycle.
module pio_sync_edge
    import pio_gen2_pkg::*;
#(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pin_i,
    output logic [W-1:0] in_sync_o,
    output logic [W-1:0] edge_pulse_o
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] in_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_prev_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync_o = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_MODE == EDGE_FALL) begin : g_fall
            assign edge_pulse_o = ~in_sync_o & in_prev_q;
        end else if (EDGE_MODE == EDGE_ANY) begin : g_any
            assign edge_pulse_o = in_sync_o ^ in_prev_q;
        end else begin : g_rise
            assign edge_pulse_o = in_sync_o & ~in_prev_q;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM PIO with direction, synchronised edge capture and masked level irq; zero-wait reads, irq 1 cycle
// after edgecap. No backpressure. Optional OUTSET/OUTCLR atomic bit updates when PIO_BITSET_EN is defined.
module avalon_pio_gen2
    import pio_gen2_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter logic [DATA_W-1:0] DIR_RESET   = '1,
    parameter int                SYNC_STAGES = 2,
    parameter int                EDGE_MODE   = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] out_oe,
    output logic              irq
);

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] irqmask_q, irqmask_d;
    logic [DATA_W-1:0] edgecap_q, edgecap_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              irq_q, irq_d;

    logic [DATA_W-1:0] in_sync;
    logic [DATA_W-1:0] edge_pulse;
    logic [DATA_W-1:0] edge_det;
    logic [DATA_W-1:0] w1c;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       rdata;
    logic              wr_en;
    logic              warm_ok;

    pio_sync_edge #(
        .W           (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .pin_i        (in_port),
        .in_sync_o    (in_sync),
        .edge_pulse_o (edge_pulse)
    );

    assign wr_en   = chipselect && !write_n;
    assign wdata   = writedata[DATA_W-1:0];
    // Pins already high at reset would look like rising edges until the synchroniser fills.
    assign warm_ok  = (warm_q == WARM_DONE);
    assign edge_det = warm_ok ? edge_pulse : '0;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        w1c        = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out_d = wdata;
                ADDR_DIR:     dir_d      = wdata;
                ADDR_IRQMASK: irqmask_d  = wdata;
                ADDR_EDGECAP: w1c        = wdata;
`ifdef PIO_BITSET_EN
                ADDR_OUTSET:  data_out_d = data_out_q | wdata;
                ADDR_OUTCLR:  data_out_d = data_out_q & ~wdata;
`endif
                default: ;
            endcase
        end
        // A fresh edge outranks a simultaneous clear of the same bit.
        edgecap_d = (edgecap_q & ~w1c) | edge_det;
        warm_d    = warm_ok ? warm_q : warm_q + WARM_W'(1);
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            dir_q      <= DIR_RESET;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            warm_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            warm_q     <= warm_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_DATA:    rdata[DATA_W-1:0] = (dir_q & data_out_q) | (~dir_q & in_sync);
            ADDR_DIR:     rdata[DATA_W-1:0] = dir_q;
            ADDR_IRQMASK: rdata[DATA_W-1:0] = irqmask_q;
            ADDR_EDGECAP: rdata[DATA_W-1:0] = edgecap_q;
            default:      rdata = '0;
        endcase
    end

    assign readdata = rdata;
    assign out_port = data_out_q;
    assign out_oe   = dir_q;
    assign irq      = irq_q;

endmodule
